xor_parity_acc: RTL
===================

XOR_PARITY_ACC -- requirements
Module: xor_parity_acc

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: number of bits per frame, legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 8: width of the bit-position counter; FRAME_LEN-1 must fit in CNT_W bits.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_bit is valid this cycle.
REQ-006 SHALL have port in_bit, input, 1: serial bit from the upstream XOR gate output.
REQ-007 SHALL have port in_ready, output, 1: the block accepts in_bit this cycle.
REQ-008 SHALL have port out_valid, output, 1: out_parity holds a completed frame result.
REQ-009 SHALL have port out_parity, output, 1: parity of the last completed frame.
REQ-010 SHALL have port out_ready, input, 1: the consumer takes the result this cycle.
REQ-011 SHALL have port frame_pos, output, CNT_W: count of bits accepted so far in the current frame.

Function
REQ-012 SHALL be a 2-state FSM: ACCUM and HOLD.
REQ-013 SHALL drive in_ready=1 in ACCUM and in_ready=0 in HOLD; out_valid=1 only in HOLD.
REQ-014 SHALL define accept = in_valid & in_ready; in ACCUM each accept does acc <= acc ^ in_bit and frame_pos <= frame_pos+1.
REQ-015 SHALL, in ACCUM, on an accept with frame_pos==FRAME_LEN-1:
  - register out_parity <= acc ^ in_bit, with the optional inversion of REQ-025;
  - clear acc and frame_pos to 0;
  - enter HOLD.
REQ-016 SHALL assert out_valid exactly 1 cycle after the final bit is accepted (latency 1).
REQ-017 SHALL, in ACCUM with in_valid=0, hold acc and frame_pos unchanged; idle gaps inside a frame are legal.
REQ-018 SHALL, in HOLD, keep out_parity and out_valid stable until out_valid & out_ready.
REQ-019 SHALL, on out_valid & out_ready in HOLD, return to ACCUM next cycle; in_ready rises 1 cycle after the handshake cycle.
REQ-020 SHALL ignore in_valid/in_bit in HOLD: no state change, and the bit is not consumed.
REQ-021 SHALL ignore out_ready in ACCUM.
REQ-022 SHALL keep out_parity holding its last value when out_valid=0.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state=ACCUM, acc=0, frame_pos=0, out_parity=0, out_valid=0, and in_ready=1 from the next cycle; rst overrides any concurrent accept or handshake.
REQ-024 SHALL discard a partially accumulated frame or a pending HOLD result on mid-operation reset, with no output produced.

Configuration
REQ-025 SHALL support macro XOR_PARITY_ACC_ODD_EN:
  - defined: out_parity = ~(XOR of frame bits), i.e. odd parity;
  - undefined: out_parity = XOR of frame bits, i.e. even parity;
  - no port or timing difference between the two builds.

Verification (FRAME_LEN=4, macro undefined unless stated)
REQ-026 SHALL cover: bits 1,0,1,1 on consecutive cycles, out_ready=1 -> out_valid=1 the cycle after the 4th bit, out_parity=1, frame_pos=0, in_ready=1 again 2 cycles after the 4th bit.
REQ-027 SHALL cover: bits 1,1,0,0 with in_valid low 3 cycles between bits 2 and 3 -> frame_pos holds 2 during the gap, out_parity=0.
REQ-028 SHALL cover: frame complete, out_ready=0 for 5 cycles with in_valid=1, in_bit=1 -> out_valid and out_parity stable, in_ready=0, frame_pos=0; the next frame starts only after the handshake.
REQ-029 SHALL cover: rst=1 after 2 accepted bits -> frame_pos=0 and out_valid=0 next cycle; a new frame 0,0,0,1 -> out_parity=1.
REQ-030 SHALL cover: rst=1 in the same cycle as out_valid&out_ready -> state ACCUM, out_parity=0.
REQ-031 SHALL cover: XOR_PARITY_ACC_ODD_EN defined, bits 1,0,1,0 -> out_parity=1.

Source files
------------

// File: rtl/xor_parity_acc.sv
// Serial XOR parity accumulator: folds FRAME_LEN accepted bits into one parity
// result and holds it until the consumer handshakes. Define XOR_PARITY_ACC_ODD_EN for odd parity.
module xor_parity_acc #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_parity,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_pos
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

`ifdef XOR_PARITY_ACC_ODD_EN
  localparam logic PARITY_INV = 1'b1;
`else
  localparam logic PARITY_INV = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] POS_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             parity_q, parity_d;
  logic             accept;

  assign accept = in_valid && (state_q == ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      acc_q    <= 1'b0;
      pos_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      pos_q    <= pos_d;
      parity_q <= parity_d;
    end
  end

  // The last bit of a frame bypasses acc so the result is ready one cycle later.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pos_d    = pos_q;
    parity_d = parity_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (pos_q == LAST_POS) begin
            parity_d = acc_q ^ in_bit ^ PARITY_INV;
            acc_d    = 1'b0;
            pos_d    = '0;
            state_d  = HOLD;
          end else begin
            acc_d = acc_q ^ in_bit;
            pos_d = pos_q + POS_ONE;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_parity = parity_q;
  assign frame_pos  = pos_q;

endmodule
